// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 matrix keypad scanner.
// Holds key codes, the per-frame scan result type, the stable-key state
// encoding and the row/column to key-code mapping.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    // Outcome of one full scan frame
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } frame_res_e;

    // Debounced key state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        BLOCK = 2'd2
    } stable_e;

    // Frame result payload; code is KEY_NONE unless kind is KEY
    typedef struct packed {
        frame_res_e kind;
        logic [3:0] code;
    } frame_res_t;

    // Rows 0..2 carry digits 1..9 left to right; row 3 is *, 0, #
    function automatic logic [3:0] rc_to_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] r4;
        logic [3:0] c4;
        r4 = {2'b00, row};
        c4 = {2'b00, col};
        if (row == 2'd3) begin
            case (col)
                2'd0:    return KEY_STAR;
                2'd1:    return KEY_0;
                default: return KEY_HASH;
            endcase
        end
        return r4 * 4'd3 + c4 + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle.
//   key_col   : column lines, active-low (board -> scanner)
//   key_row   : row drive, active-low one-cold (scanner -> board)
//   keypad    : one-hot stable digit
//   key_code  : stable key code, 15 = none
//   key_valid : one-cycle pulse on a new debounced press
//   key_star  : * held
//   key_hash  : # held
// master = scanner side, slave = board/consumer side.
interface keypad_scanner_if;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_star;
    logic       key_hash;

    modport master (
        input  key_col,
        output key_row, keypad, key_code, key_valid, key_star, key_hash
    );

    modport slave (
        output key_col,
        input  key_row, keypad, key_code, key_valid, key_star, key_hash
    );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce and stable-key FSM.
// Ports:
//   clk, rst      : clock, async active-low reset
//   frame_end     : strobe on the last cycle of a scan frame
//   res           : that frame's result
//   stable_state  : debounced state (IDLE/HELD/BLOCK)
//   stable_code   : debounced key code, KEY_NONE unless HELD
//   key_valid     : one-cycle pulse on IDLE->HELD (plus repeats if enabled)
// Optional auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEB_FRAMES    = 2,
    parameter int unsigned REPEAT_DELAY  = 32,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  frame_res_t res,
    output logic [1:0] stable_state,
    output logic [3:0] stable_code,
    output logic       key_valid
);

    localparam int unsigned MW = $clog2(DEB_FRAMES + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_HELD  = HELD;
    localparam logic [1:0] S_BLOCK = BLOCK;

    frame_res_t    prev_q, prev_d;
    logic [MW-1:0] match_q, match_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic [1:0]    res_state_c;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RW = 16;
    logic [RW-1:0] rep_q, rep_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= '{kind: NONE, code: KEY_NONE};
            match_q <= '0;
            state_q <= S_IDLE;
            code_q  <= KEY_NONE;
            valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            prev_q  <= prev_d;
            match_q <= match_d;
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Match counting, stable update and pulse generation
    always_comb begin
        prev_d  = prev_q;
        match_d = match_q;
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (res.kind)
            NONE:    res_state_c = S_IDLE;
            KEY:     res_state_c = S_HELD;
            default: res_state_c = S_BLOCK;
        endcase

        if (frame_end) begin
            prev_d = res;
            if (res == prev_q) begin
                match_d = (match_q == MW'(DEB_FRAMES)) ? match_q : match_q + MW'(1);
            end else begin
                match_d = MW'(1);
            end

            if (match_d == MW'(DEB_FRAMES) &&
                (res_state_c != state_q || res.code != code_q)) begin
                state_d = res_state_c;
                code_d  = res.code;
                // Only a press from idle is a new key; BLOCK->HELD or a code swap is silent
                valid_d = (state_q == S_IDLE) && (res_state_c == S_HELD);
            end

`ifdef KEYPAD_REPEAT_EN
            // Countdown to next repeat; reloaded on any state change
            if (state_d != state_q || code_d != code_q) begin
                rep_d = RW'(REPEAT_DELAY);
            end else if (state_q == S_HELD) begin
                if (rep_q <= RW'(1)) begin
                    valid_d = 1'b1;
                    rep_d   = RW'(REPEAT_PERIOD);
                end else begin
                    rep_d = rep_q - RW'(1);
                end
            end
`endif
        end
    end

    assign stable_state = state_q;
    assign stable_code  = code_q;
    assign key_valid    = valid_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column synchronizer, frame
// accumulator and registered output decode around keypad_debounce.
// Ports:
//   clk  : system clock (1 kHz)
//   rst  : async active-low reset
//   kif  : keypad_scanner_if.master (key_col in; key_row, keypad, key_code,
//          key_valid, key_star, key_hash out)
// Build option: KEYPAD_REPEAT_EN enables auto-repeat pulses on key_valid.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROW_CYC       = 4,
    parameter int unsigned DEB_FRAMES    = 2,
    parameter int unsigned REPEAT_DELAY  = 32,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scanner_if.master   kif
);

    localparam int unsigned SW = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;

    logic [2:0]    col_s1_q, col_s2_q;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    key_row_q, key_row_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [9:0]    keypad_q, keypad_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_star_q, key_star_d;
    logic          key_hash_q, key_hash_d;

    logic          slot_last_c, frame_end_c;
    logic [1:0]    cnt_c;
    logic [3:0]    code_c;
    frame_res_t    res_c;
    logic [1:0]    stable_state;
    logic [3:0]    stable_code;
    logic          deb_valid;

    // Registers; idle columns read as all-open
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q    <= 3'b111;
            col_s2_q    <= 3'b111;
            slot_q      <= '0;
            row_q       <= 2'd0;
            key_row_q   <= 4'b1110;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= KEY_NONE;
            keypad_q    <= '0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_star_q  <= 1'b0;
            key_hash_q  <= 1'b0;
        end else begin
            col_s1_q    <= kif.key_col;
            col_s2_q    <= col_s1_q;
            slot_q      <= slot_d;
            row_q       <= row_d;
            key_row_q   <= key_row_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            keypad_q    <= keypad_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_star_q  <= key_star_d;
            key_hash_q  <= key_hash_d;
        end
    end

    // Scan counters and row drive; row wraps 3->0 without a gap
    always_comb begin
        slot_last_c = (slot_q == SW'(ROW_CYC - 1));
        frame_end_c = slot_last_c && (row_q == 2'd3);
        slot_d      = slot_last_c ? '0 : slot_q + SW'(1);
        row_d       = slot_last_c ? row_q + 2'd1 : row_q;
        key_row_d   = ~(4'b0001 << row_d);
    end

    // Frame accumulator; the final row's sample is folded in before the frame closes
    always_comb begin
        cnt_c  = acc_cnt_q;
        code_c = acc_code_q;
        if (slot_last_c) begin
            for (int c = 0; c < 3; c++) begin
                if (!col_s2_q[c]) begin
                    if (cnt_c == 2'd0) code_c = rc_to_code(row_q, 2'(c));
                    if (cnt_c != 2'd2) cnt_c = cnt_c + 2'd1;
                end
            end
        end

        res_c.kind = (cnt_c == 2'd0) ? NONE : (cnt_c == 2'd1) ? KEY : MULTI;
        res_c.code = (cnt_c == 2'd1) ? code_c : KEY_NONE;

        acc_cnt_d  = frame_end_c ? 2'd0 : cnt_c;
        acc_code_d = frame_end_c ? KEY_NONE : code_c;
    end

    keypad_debounce #(
        .DEB_FRAMES    (DEB_FRAMES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .frame_end    (frame_end_c),
        .res          (res_c),
        .stable_state (stable_state),
        .stable_code  (stable_code),
        .key_valid    (deb_valid)
    );

    // Output decode; BLOCK and IDLE both read as no key
    always_comb begin
        keypad_d    = '0;
        key_code_d  = KEY_NONE;
        key_star_d  = 1'b0;
        key_hash_d  = 1'b0;
        key_valid_d = deb_valid;
        if (stable_state == 2'(HELD)) begin
            key_code_d = stable_code;
            if (stable_code <= KEY_9) keypad_d = 10'd1 << stable_code;
            key_star_d = (stable_code == KEY_STAR);
            key_hash_d = (stable_code == KEY_HASH);
        end
    end

    assign kif.key_row   = key_row_q;
    assign kif.keypad    = keypad_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_star  = key_star_q;
    assign kif.key_hash  = key_hash_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with default parameters.
// A matrix model closes columns against the driven row; expected key_valid
// events are queued when keys are pressed and matched against captured pulses.
module tb_keypad_scanner;

    logic clk;
    logic rst;
    logic [11:0] pressed;   // index = row*3 + col
    logic [2:0]  col_c;

    keypad_scanner_if kif();

    keypad_scanner #(
        .ROW_CYC       (4),
        .DEB_FRAMES    (2),
        .REPEAT_DELAY  (32),
        .REPEAT_PERIOD (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_c = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3 + c] && !kif.key_row[r]) col_c[c] = 1'b0;
    end
    assign kif.key_col = col_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [13:0] exp_q[$];
    logic [13:0] obs_mem[64];
    int          obs_n = 0;
    int          rd = 0;
    logic        in_bounce = 1'b0;
    int          bad_code_cnt = 0;

    // Capture every key_valid pulse with the code/keypad shown alongside it
    always @(negedge clk) begin
        if (kif.key_valid) begin
            if (obs_n < 64) obs_mem[obs_n] = {kif.key_code, kif.keypad};
            obs_n = obs_n + 1;
        end
    end

    always @(negedge clk) begin
        if (in_bounce && kif.key_code != 4'd3 && kif.key_code != 4'd15)
            bad_code_cnt = bad_code_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [13:0] exp_evt(input logic [3:0] code);
        logic [9:0] oh;
        oh = (code <= 4'd9) ? (10'd1 << code) : 10'd0;
        return {code, oh};
    endfunction

    // Match queued expectations against captured pulses, then demand no extras
    task automatic drain(input string tag);
        logic [13:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_n && rd < 64) begin
                check({tag, " pulse"}, 32'(obs_mem[rd]), 32'(e));
                rd++;
            end else begin
                check({tag, " pulse count"}, 32'(obs_n), 32'(rd + 1));
            end
        end
        check({tag, " no extra pulse"}, 32'(obs_n), 32'(rd));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " keypad"},   32'(kif.keypad),   32'(0));
        check({tag, " key_code"}, 32'(kif.key_code), 32'(15));
        check({tag, " star"},     32'(kif.key_star), 32'(0));
        check({tag, " hash"},     32'(kif.key_hash), 32'(0));
    endtask

    initial begin
        pressed = '0;
        rst     = 1'b0;
        tick(3);

        // Reset values
        check("rst key_row", 32'(kif.key_row), 32'(4'b1110));
        check("rst valid",   32'(kif.key_valid), 32'(0));
        check_idle("rst");
        rst = 1'b1;
        tick(40);
        check_idle("post-rst");

        // Clean press of 5
        pressed[4] = 1'b1;
        exp_q.push_back(exp_evt(4'd5));
        tick(100);
        check("key5 keypad",   32'(kif.keypad),   32'(10'b0000100000));
        check("key5 key_code", 32'(kif.key_code), 32'(5));
        pressed[4] = 1'b0;
        tick(60);
        check_idle("key5 release");
        drain("key5");

        // Bounce on 3, then hold
        in_bounce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pressed[2] = ~pressed[2];
            tick(3);
        end
        pressed[2] = 1'b1;
        exp_q.push_back(exp_evt(4'd3));
        tick(80);
        check("bounce key_code", 32'(kif.key_code), 32'(3));
        check("bounce keypad",   32'(kif.keypad),   32'(10'b0000001000));
        pressed[2] = 1'b0;
        tick(60);
        in_bounce = 1'b0;
        check("bounce stray codes", 32'(bad_code_cnt), 32'(0));
        check_idle("bounce release");
        drain("bounce");

        // Two keys at once, then release one
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        tick(60);
        check_idle("multi");
        pressed[1] = 1'b0;
        tick(60);
        check("multi->1 keypad",   32'(kif.keypad),   32'(10'b0000000010));
        check("multi->1 key_code", 32'(kif.key_code), 32'(1));
        pressed[0] = 1'b0;
        tick(60);
        check_idle("multi release");
        drain("multi");

        // Star
        pressed[9] = 1'b1;
        exp_q.push_back(exp_evt(4'd10));
        tick(100);
        check("star flag",     32'(kif.key_star), 32'(1));
        check("star hash",     32'(kif.key_hash), 32'(0));
        check("star keypad",   32'(kif.keypad),   32'(0));
        check("star key_code", 32'(kif.key_code), 32'(10));
        pressed[9] = 1'b0;
        tick(60);
        check_idle("star release");
        drain("star");

        // Hash
        pressed[11] = 1'b1;
        exp_q.push_back(exp_evt(4'd11));
        tick(100);
        check("hash flag",     32'(kif.key_hash), 32'(1));
        check("hash star",     32'(kif.key_star), 32'(0));
        check("hash key_code", 32'(kif.key_code), 32'(11));
        pressed[11] = 1'b0;
        tick(60);
        check_idle("hash release");
        drain("hash");

        // Reset while 9 is held
        pressed[8] = 1'b1;
        exp_q.push_back(exp_evt(4'd9));
        tick(100);
        check("key9 key_code", 32'(kif.key_code), 32'(9));
        drain("key9");
        rst = 1'b0;
        #1;
        check("midrst key_row", 32'(kif.key_row),   32'(4'b1110));
        check("midrst valid",   32'(kif.key_valid), 32'(0));
        check_idle("midrst");
        tick(3);
        rst = 1'b1;
        exp_q.push_back(exp_evt(4'd9));
        tick(100);
        check("key9 again keypad", 32'(kif.keypad), 32'(10'b1000000000));
        pressed[8] = 1'b0;
        tick(60);
        check_idle("key9 release");
        drain("key9 after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the watch and other keypad-driven blocks. Scans a 4x3 matrix (1–9, \*, 0, #) by driving one row low at a time and sampling the columns. Debounces each full scan frame and produces the one-hot, level-style `keypad[9:0]` bus that the time-setting logic consumes, plus a code and a press pulse. It sits between the board's keypad pins and the watch, and runs on the same 1 kHz system clock.

## Interface
Parameters:
- `ROW_CYC`, 4: clock cycles each row is driven; must be at least 3.
- `DEB_FRAMES`, 2: number of consecutive identical frames required before the stable key changes.
- `REPEAT_DELAY`, 32: frames from press to the first repeat pulse. Used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_PERIOD`, 8: frames between subsequent repeat pulses. Used only with `KEYPAD_REPEAT_EN`.

Ports:
- `clk` input 1: system clock, 1 kHz.
- `rst` input 1: asynchronous, active-low reset.
- `key_col` input 3: column lines, active-low, externally pulled up, asynchronous to `clk`.
- `key_row` output 4: row drive, active-low, exactly one bit low at a time.
- `keypad` output 10: one-hot stable digit; bit n set while digit n is held; 0 otherwise.
- `key_code` output 4: stable key code (0–9, 10 = \*, 11 = #, 15 = none).
- `key_valid` output 1: one-cycle pulse on a new debounced press.
- `key_star` output 1: level, set while \* is stably held.
- `key_hash` output 1: level, set while # is stably held.

## Operation
- **Column sync:** `key_col` passes through a 2-flop synchronizer before any use.
- **Row to key mapping:**
  - Row 0, columns 0/1/2 = 1/2/3.
  - Row 1 = 4/5/6.
  - Row 2 = 7/8/9.
  - Row 3 = \*/0/#.
- **Scan:**
  - A slot counter runs 0..`ROW_CYC`-1 per row.
  - The row index runs 0..3 and wraps.
  - Synchronized columns are sampled on the last cycle of each slot.
  - One frame is 4 rows, i.e. 4·`ROW_CYC` cycles.
- **Frame accumulator:**
  - Counts closed contacts, saturating at 2, and records the code of the first one found.
  - At frame end the result is NONE (0 contacts), KEY(code) (1 contact) or MULTI (2 or more).
  - The accumulator clears for the next frame.
- **Debounce:**
  - The frame result is compared against the previous frame result.
  - If equal, the match counter increments (saturating); otherwise it is set to 1.
  - When the counter reaches `DEB_FRAMES` and the result differs from `stable`, `stable` takes the result.
- **Stable FSM:** states IDLE (NONE), HELD(code), BLOCK (MULTI).
  - IDLE→HELD: `key_valid` pulses.
  - HELD→HELD with a different code, or BLOCK→HELD: no pulse; a release to IDLE is required before the next pulse.
  - Any state→BLOCK: outputs read as no key.
  - →IDLE: all outputs clear.
- **Outputs:** registered and decoded from `stable`.
  - `keypad` is nonzero only for codes 0–9.
  - `key_star` / `key_hash` are set only for codes 10 / 11.
  - `key_code` = 15 in IDLE and BLOCK.

## Timing
- **Reset values:**
  - `key_row` = 4'b1110.
  - `keypad` = 0, `key_code` = 15.
  - `key_valid`, `key_star`, `key_hash` = 0.
  - Slot, row, match and accumulator counters = 0; `stable` = IDLE.
- **Press latency:** outputs update 1 cycle after the end of the `DEB_FRAMES`-th consecutive identical frame.
  - Defaults: 2–3 frames, i.e. 32–48 ms from a clean press.
- **Release latency:** the same latency applies on release.
- **`key_valid`:** asserted in the same cycle that `keypad`/`key_code` first show the new key.
- **Partial frames:** a press or release mid-frame makes that frame's result whatever was sampled; debounce absorbs it.
- **Reset mid-operation:** reset aborts everything. If a key is still held after reset release, it is detected as a fresh press and produces one pulse after debounce.
- **Counter wrap:** the match counter saturates at `DEB_FRAMES`, and the row index wraps 3→0 with no idle cycle.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - While in HELD, a frame counter runs.
  - `key_valid` re-pulses `REPEAT_DELAY` frames after the press, then every `REPEAT_PERIOD` frames.
  - The counter clears on any state change.
- **Not defined:** exactly one `key_valid` per press; no repeat counter is synthesized.

## Structure
- **Package `keypad_pkg`:**
  - Constants KEY_0..KEY_9 (= 0..9), KEY_STAR = 10, KEY_HASH = 11, KEY_NONE = 15.
  - Frame-result enum NONE/KEY/MULTI.
  - Stable-state enum IDLE/HELD/BLOCK.
  - Function `rc_to_code(row, col)`.
- **Sub-module `keypad_debounce`:** takes the frame result plus a frame-end strobe and produces `stable` and `key_valid`. It contains the match counter, the stable FSM and the optional repeat logic.
- **Top level:** synchronizer, scan counters, row drive, accumulator and output decode.

## Test plan
- **Clean press of 5:** press (row 1 / col 1) for 100 ms with defaults → `keypad` = 10'b0000100000, `key_code` = 5, one `key_valid`. After release, `keypad` = 0 and `key_code` = 15 within 48 ms.
- **Bounce:** key 3 toggles every 3 ms for 12 ms, then holds for 80 ms → exactly one `key_valid`; `key_code` never shows any value other than 3 or 15.
- **Two keys:** 1 and 2 pressed together → BLOCK, `keypad` = 0, no pulse. Release 2 while holding 1 → `keypad` = 10'b0000000010 with no `key_valid`.
- **Special keys:** \* held → `key_star` = 1, `keypad` = 0, `key_code` = 10, one pulse. # held → `key_hash` = 1.
- **Reset mid-press:** assert `rst` low while 9 is held → all outputs go to reset values immediately. Deassert with 9 still held → one new `key_valid` after debounce.
- **Repeat (`KEYPAD_REPEAT_EN` defined):** hold 7 for 800 ms → pulses at press, +32 frames, then every 8 frames.
